// File: rtl/tlb_cp0_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tlb_cp0_ctrl_pkg
//
// Shared definitions for the CP0 TLB controller slice: TLB instruction and
// request encodings, the record exchanged with the TLB, CP0 register numbers
// and the writable-bit masks of each register.
//
// No ports (package).
// ---------------------------------------------------------------------------
package tlb_cp0_ctrl_pkg;

  // Width of a TLB index; the controller is sized for up to 32 entries.
  localparam int INDEX_W = 5;

  // CP0 register numbers handled by this block.
  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_PAGEMASK = 5'd5;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  // Software-writable bits of each register; everything else reads as 0.
  localparam logic [31:0] INDEX_MASK   = 32'h0000_001F;
  localparam logic [31:0] ENTRYLO_MASK = 32'h03FF_FFFF;
  localparam logic [31:0] WIRED_MASK   = 32'h0000_001F;
  localparam logic [31:0] ENTRYHI_MASK = 32'hFFFF_E0FF;

  // TLB instruction presented by the pipeline.
  typedef enum logic [1:0] {
    OP_TLBP,
    OP_TLBR,
    OP_TLBWI,
    OP_TLBWR
  } tlb_op_t;

  // Request driven to the TLB; REQ_NONE whenever no operation is in flight.
  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_TLBP,
    REQ_TLBR,
    REQ_TLBWI,
    REQ_TLBWR
  } tlb_req_t;

  // Entry image exchanged with the TLB in both directions.
  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [31:0]        entryhi;
    logic [31:0]        entrylo0;
    logic [31:0]        entrylo1;
    logic [31:0]        pagemask;
  } tlb_t;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_WB
  } ctrl_state_t;

  // Map a pipeline instruction onto the matching TLB request code.
  function automatic tlb_req_t op_to_req(tlb_op_t op);
    tlb_req_t req;
    case (op)
      OP_TLBP:  req = REQ_TLBP;
      OP_TLBR:  req = REQ_TLBR;
      OP_TLBWI: req = REQ_TLBWI;
      OP_TLBWR: req = REQ_TLBWR;
      default:  req = REQ_NONE;
    endcase
    return req;
  endfunction

endpackage

// File: rtl/tlb_cp0_ctrl_if.sv
// ---------------------------------------------------------------------------
// tlb_cp0_ctrl_if
//
// Bundles every non-clock signal of the CP0 TLB controller.
//   Pipeline side : op_valid, op_code, op_ready, op_done
//   MTC0/MFC0     : cp0_we, cp0_waddr, cp0_wdata, cp0_raddr, cp0_rdata
//   Exceptions    : exc_valid, exc_vaddr
//   TLB side      : tlb_req, tlb_info, tlb_res, tlb_done,
//                   tlb_probe_hit, tlb_probe_idx
// Modport slave is the controller's view; master is the surrounding
// pipeline/TLB environment.
// ---------------------------------------------------------------------------
interface tlb_cp0_ctrl_if import tlb_cp0_ctrl_pkg::*; ();

  logic               op_valid;
  tlb_op_t            op_code;
  logic               op_ready;
  logic               op_done;

  logic               cp0_we;
  logic [4:0]         cp0_waddr;
  logic [31:0]        cp0_wdata;
  logic [4:0]         cp0_raddr;
  logic [31:0]        cp0_rdata;

  logic               exc_valid;
  logic [31:0]        exc_vaddr;

  tlb_req_t           tlb_req;
  tlb_t               tlb_info;
  tlb_t               tlb_res;
  logic               tlb_done;
  logic               tlb_probe_hit;
  logic [INDEX_W-1:0] tlb_probe_idx;

  modport slave (
    input  op_valid, op_code,
    input  cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    input  exc_valid, exc_vaddr,
    input  tlb_res, tlb_done, tlb_probe_hit, tlb_probe_idx,
    output op_ready, op_done, cp0_rdata, tlb_req, tlb_info
  );

  modport master (
    output op_valid, op_code,
    output cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    output exc_valid, exc_vaddr,
    output tlb_res, tlb_done, tlb_probe_hit, tlb_probe_idx,
    input  op_ready, op_done, cp0_rdata, tlb_req, tlb_info
  );

endinterface

// File: rtl/tlb_cp0_ctrl_random.sv
// ---------------------------------------------------------------------------
// tlb_random
//
// Holds the CP0 Wired register and the free-running Random replacement
// pointer. Random counts down once per cycle from TLBEntries-1 and wraps
// back to the top after reaching Wired (or 0), so the wired entries below
// it are never chosen by TLBWR.
//
// Ports:
//   clk, resetn    clock and asynchronous active-low reset
//   wired_we_i     MTC0 write to Wired this cycle
//   wired_wdata_i  MTC0 write data (masked to the Wired field here)
//   random_o       current Random value
//   wired_o        current Wired value
// ---------------------------------------------------------------------------
module tlb_random import tlb_cp0_ctrl_pkg::*; #(
  parameter int TLBEntries = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wired_we_i,
  input  logic [31:0]        wired_wdata_i,
  output logic [INDEX_W-1:0] random_o,
  output logic [INDEX_W-1:0] wired_o
);

  localparam logic [INDEX_W-1:0] RandomTop = INDEX_W'(TLBEntries - 1);

  logic [INDEX_W-1:0] random_q, random_d;
  logic [INDEX_W-1:0] wired_q, wired_d;
  logic               wiredOutOfRange;

  // A Wired value that covers the whole TLB leaves no replaceable entry,
  // so Random is pinned at the top in that case.
  assign wiredOutOfRange = (32'(wired_q) >= 32'(TLBEntries));

  // Next Random/Wired: a Wired write restarts the countdown from the top;
  // otherwise count down and wrap at the Wired boundary or at zero.
  always_comb begin
    wired_d  = wired_q;
    random_d = random_q;
    if (wired_we_i) begin
      wired_d  = INDEX_W'(wired_wdata_i & WIRED_MASK);
      random_d = RandomTop;
    end else if (wiredOutOfRange) begin
      random_d = RandomTop;
    end else if ((random_q == wired_q) || (random_q == '0)) begin
      random_d = RandomTop;
    end else begin
      random_d = random_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_q <= RandomTop;
      wired_q  <= '0;
    end else begin
      random_q <= random_d;
      wired_q  <= wired_d;
    end
  end

  assign random_o = random_q;
  assign wired_o  = wired_q;

endmodule

// File: rtl/tlb_cp0_ctrl.sv
// ---------------------------------------------------------------------------
// tlb_cp0_ctrl
//
// CP0 side of TLB management. Owns Index, EntryLo0/1, EntryHi (and, through
// tlb_random, Random and Wired), sequences TLBP/TLBR/TLBWI/TLBWR against an
// external TLB and writes the results back into CP0.
//
// Ports:
//   clk     sole clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     tlb_cp0_ctrl_if.slave: pipeline handshake, MTC0/MFC0 port,
//           exception commit, and the TLB request/response signals
//
// Operation flow: IDLE accepts an op and snapshots the entry image, REQ and
// WAIT present it to the TLB, WB writes the result back and pulses op_done.
// An exception commit while busy abandons the op without writeback.
// ---------------------------------------------------------------------------
module tlb_cp0_ctrl import tlb_cp0_ctrl_pkg::*; #(
  parameter int TLBEntries = 32
) (
  input logic           clk,
  input logic           resetn,
  tlb_cp0_ctrl_if.slave bus
);

  ctrl_state_t        state_q, state_d;
  tlb_op_t            op_q, op_d;
  tlb_t               info_q, info_d;

  // TLB response captured on tlb_done, consumed in WB.
  logic               probeHit_q, probeHit_d;
  logic [INDEX_W-1:0] probeIdx_q, probeIdx_d;
  logic [31:0]        resHi_q, resHi_d;
  logic [31:0]        resLo0_q, resLo0_d;
  logic [31:0]        resLo1_q, resLo1_d;

  // CP0 registers.
  logic               indexP_q, indexP_d;
  logic [INDEX_W-1:0] indexVal_q, indexVal_d;
  logic [31:0]        entryLo0_q, entryLo0_d;
  logic [31:0]        entryLo1_q, entryLo1_d;
  logic [31:0]        entryHi_q, entryHi_d;

  logic [INDEX_W-1:0] randomVal;
  logic [INDEX_W-1:0] wiredVal;
  logic               wiredWe;

  logic               opReady;
  logic               wbEn;
  tlb_req_t           tlbReq;
  logic [31:0]        rdata;

  // Only the entry fields of tlb_res and the VPN2 part of exc_vaddr matter.
  logic               unusedBits;
  assign unusedBits = ^{bus.tlb_res.index, bus.tlb_res.pagemask, bus.exc_vaddr[12:0]};

  tlb_random #(
    .TLBEntries (TLBEntries)
  ) u_random (
    .clk           (clk),
    .resetn        (resetn),
    .wired_we_i    (wiredWe),
    .wired_wdata_i (bus.cp0_wdata),
    .random_o      (randomVal),
    .wired_o       (wiredVal)
  );

  // A committing exception blocks new ops in the same cycle so that an op
  // never starts on a pipeline that is being flushed.
  assign opReady = (state_q == ST_IDLE) && !bus.exc_valid;

  // Sequencing: next state, op/entry snapshot at accept, response capture
  // on tlb_done, and the request/writeback strobes. The snapshot keeps
  // tlb_info stable while Random keeps counting underneath it.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    info_d     = info_q;
    probeHit_d = probeHit_q;
    probeIdx_d = probeIdx_q;
    resHi_d    = resHi_q;
    resLo0_d   = resLo0_q;
    resLo1_d   = resLo1_q;
    tlbReq     = REQ_NONE;
    wbEn       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid && opReady) begin
          state_d         = ST_REQ;
          op_d            = bus.op_code;
          info_d.index    = (bus.op_code == OP_TLBWR) ? randomVal : indexVal_q;
          info_d.entryhi  = entryHi_q;
          info_d.entrylo0 = entryLo0_q;
          info_d.entrylo1 = entryLo1_q;
          info_d.pagemask = '0;
        end
      end
      ST_REQ: begin
        tlbReq  = op_to_req(op_q);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tlbReq = op_to_req(op_q);
        if (bus.tlb_done) begin
          state_d    = ST_WB;
          probeHit_d = bus.tlb_probe_hit;
          probeIdx_d = bus.tlb_probe_idx;
          resHi_d    = bus.tlb_res.entryhi;
          resLo0_d   = bus.tlb_res.entrylo0;
          resLo1_d   = bus.tlb_res.entrylo1;
        end
      end
      ST_WB: begin
        wbEn    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Exception commit abandons whatever op is in flight.
    if (bus.exc_valid && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      wbEn    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_TLBP;
      info_q     <= '0;
      probeHit_q <= 1'b0;
      probeIdx_q <= '0;
      resHi_q    <= '0;
      resLo0_q   <= '0;
      resLo1_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      info_q     <= info_d;
      probeHit_q <= probeHit_d;
      probeIdx_q <= probeIdx_d;
      resHi_q    <= resHi_d;
      resLo0_q   <= resLo0_d;
      resLo1_q   <= resLo1_d;
    end
  end

  // Register next-state, lowest priority first: MTC0, then op writeback,
  // then exception commit. A higher-priority source takes the whole
  // register, so the lower one's write to it is discarded.
  always_comb begin
    indexP_d   = indexP_q;
    indexVal_d = indexVal_q;
    entryLo0_d = entryLo0_q;
    entryLo1_d = entryLo1_q;
    entryHi_d  = entryHi_q;
    wiredWe    = 1'b0;

    if (bus.cp0_we) begin
      case (bus.cp0_waddr)
        CP0_INDEX:    indexVal_d = INDEX_W'(bus.cp0_wdata & INDEX_MASK);
        CP0_ENTRYLO0: entryLo0_d = bus.cp0_wdata & ENTRYLO_MASK;
        CP0_ENTRYLO1: entryLo1_d = bus.cp0_wdata & ENTRYLO_MASK;
        CP0_ENTRYHI:  entryHi_d  = bus.cp0_wdata & ENTRYHI_MASK;
        CP0_WIRED:    wiredWe    = 1'b1;
        default:      ;
      endcase
    end

    if (wbEn) begin
      case (op_q)
        OP_TLBP: begin
          // A miss only raises P; the previous index is kept.
          if (probeHit_q) begin
            indexP_d   = 1'b0;
            indexVal_d = probeIdx_q;
          end else begin
            indexP_d   = 1'b1;
            indexVal_d = indexVal_q;
          end
        end
        OP_TLBR: begin
          entryHi_d  = resHi_q & ENTRYHI_MASK;
          entryLo0_d = resLo0_q & ENTRYLO_MASK;
          entryLo1_d = resLo1_q & ENTRYLO_MASK;
        end
        default: ;
      endcase
    end

    // Faulting VPN2 replaces EntryHi[31:13]; the ASID is preserved.
    if (bus.exc_valid) begin
      entryHi_d = {bus.exc_vaddr[31:13], entryHi_q[12:0]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      indexP_q   <= 1'b0;
      indexVal_q <= '0;
      entryLo0_q <= '0;
      entryLo1_q <= '0;
      entryHi_q  <= '0;
    end else begin
      indexP_q   <= indexP_d;
      indexVal_q <= indexVal_d;
      entryLo0_q <= entryLo0_d;
      entryLo1_q <= entryLo1_d;
      entryHi_q  <= entryHi_d;
    end
  end

  // MFC0 read of registered state; same-cycle writes are not forwarded.
  always_comb begin
    rdata = '0;
    case (bus.cp0_raddr)
      CP0_INDEX:    rdata = {indexP_q, (31 - INDEX_W)'(0), indexVal_q};
      CP0_RANDOM:   rdata = 32'(randomVal);
      CP0_ENTRYLO0: rdata = entryLo0_q;
      CP0_ENTRYLO1: rdata = entryLo1_q;
      CP0_WIRED:    rdata = 32'(wiredVal);
      CP0_ENTRYHI:  rdata = entryHi_q;
      default:      rdata = '0;
    endcase
  end

  assign bus.op_ready  = opReady;
  assign bus.op_done   = wbEn;
  assign bus.tlb_req   = tlbReq;
  assign bus.tlb_info  = info_q;
  assign bus.cp0_rdata = rdata;

endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tlb_cp0_ctrl
//
// Self-checking bench for tlb_cp0_ctrl: a table of MTC0/MFC0 vectors, then
// hand-written op sequences (TLBWI, TLBP hit/miss, TLBR, TLBWR), the Random
// countdown, exception abort and reset during an op.
// ---------------------------------------------------------------------------
module tb_tlb_cp0_ctrl;
  import tlb_cp0_ctrl_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  tlb_cp0_ctrl_if bus ();

  tlb_cp0_ctrl #(
    .TLBEntries (32)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Free-running clock, period 20.
  always #10 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    string       name;
    logic [4:0]  addr;
    logic [31:0] data;
  } expRead_t;

  typedef struct {
    string       name;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] expRead;
  } regVec_t;

  expRead_t expQ[$];
  regVec_t  regVecs[10];

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushRead(input string name, input logic [4:0] addr, input logic [31:0] data);
    expRead_t e;
    e.name = name;
    e.addr = addr;
    e.data = data;
    expQ.push_back(e);
  endtask

  // Pop every queued expectation and compare against an MFC0 read.
  // Called just after a falling edge; each read takes 1 time unit.
  task automatic drainReads();
    expRead_t e;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      bus.cp0_raddr = e.addr;
      #1;
      checkOutput(e.name, bus.cp0_rdata, e.data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    step();
    bus.cp0_we    = 1'b1;
    bus.cp0_waddr = addr;
    bus.cp0_wdata = data;
    step();
    bus.cp0_we    = 1'b0;
  endtask

  // One table vector: write the register, then read it back next cycle.
  task automatic applyStimulus(input regVec_t v);
    mtc0(v.waddr, v.wdata);
    @(negedge clk);
    pushRead(v.name, v.waddr, v.expRead);
    drainReads();
  endtask

  // Full op: accept, REQ, waitCycles extra WAIT cycles, tlb_done, WB.
  // An optional MTC0 is driven during the WB cycle.
  task automatic runOp(input tlb_op_t op, input tlb_req_t expReq,
                       input logic [4:0] expIdx, input logic [31:0] expHi,
                       input int waitCycles, input logic hit, input logic [4:0] pidx,
                       input tlb_t res, input logic wbWe, input logic [4:0] wbAddr,
                       input logic [31:0] wbData);
    step();
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    @(negedge clk);
    checkOutput("acceptReady", 32'(bus.op_ready), 32'd1);
    step();
    bus.op_valid = 1'b0;
    @(negedge clk);
    checkOutput("reqType", 32'(bus.tlb_req), 32'(expReq));
    checkOutput("reqIndex", 32'(bus.tlb_info.index), 32'(expIdx));
    checkOutput("reqEntryHi", bus.tlb_info.entryhi, expHi);
    checkOutput("reqPageMask", bus.tlb_info.pagemask, 32'd0);
    for (int i = 0; i < waitCycles; i++) begin
      step();
      @(negedge clk);
      checkOutput("waitReqHold", 32'(bus.tlb_req), 32'(expReq));
      checkOutput("waitIndexHold", 32'(bus.tlb_info.index), 32'(expIdx));
      checkOutput("waitNoDone", 32'(bus.op_done), 32'd0);
    end
    step();
    bus.tlb_done      = 1'b1;
    bus.tlb_probe_hit = hit;
    bus.tlb_probe_idx = pidx;
    bus.tlb_res       = res;
    @(negedge clk);
    checkOutput("doneCycleNoOpDone", 32'(bus.op_done), 32'd0);
    step();
    bus.tlb_done  = 1'b0;
    bus.cp0_we    = wbWe;
    bus.cp0_waddr = wbAddr;
    bus.cp0_wdata = wbData;
    @(negedge clk);
    checkOutput("wbOpDone", 32'(bus.op_done), 32'd1);
    checkOutput("wbReqNone", 32'(bus.tlb_req), 32'(REQ_NONE));
    step();
    bus.cp0_we        = 1'b0;
    bus.tlb_probe_hit = 1'b0;
    bus.tlb_probe_idx = '0;
    bus.tlb_res       = '0;
    @(negedge clk);
    checkOutput("postOpDoneLow", 32'(bus.op_done), 32'd0);
    checkOutput("postReady", 32'(bus.op_ready), 32'd1);
  endtask

  // Guard against a stuck run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tlb_t res;
    logic [31:0] expRandom;

    regVecs[0] = '{"indexMask",    CP0_INDEX,    32'hFFFF_FFFF, 32'h0000_001F};
    regVecs[1] = '{"indexWrite",   CP0_INDEX,    32'h0000_0012, 32'h0000_0012};
    regVecs[2] = '{"lo0Mask",      CP0_ENTRYLO0, 32'hFFFF_FFFF, 32'h03FF_FFFF};
    regVecs[3] = '{"lo1Mask",      CP0_ENTRYLO1, 32'hA5A5_A5A5, 32'h01A5_A5A5};
    regVecs[4] = '{"hiMaskOnes",   CP0_ENTRYHI,  32'hFFFF_FFFF, 32'hFFFF_E0FF};
    regVecs[5] = '{"hiMaskMixed",  CP0_ENTRYHI,  32'h1234_5678, 32'h1234_4078};
    regVecs[6] = '{"pageMaskRO",   CP0_PAGEMASK, 32'hFFFF_FFFF, 32'h0000_0000};
    regVecs[7] = '{"wiredMask",    CP0_WIRED,    32'hFFFF_FFE3, 32'h0000_0003};
    regVecs[8] = '{"unmappedReg",  5'd4,         32'hDEAD_BEEF, 32'h0000_0000};
    // Wired=3 write restarted Random at 31; four more edges elapse by this read.
    regVecs[9] = '{"randomRO",     CP0_RANDOM,   32'h0000_0000, 32'h0000_001B};

    bus.op_valid      = 1'b0;
    bus.op_code       = OP_TLBP;
    bus.cp0_we        = 1'b0;
    bus.cp0_waddr     = '0;
    bus.cp0_wdata     = '0;
    bus.cp0_raddr     = '0;
    bus.exc_valid     = 1'b0;
    bus.exc_vaddr     = '0;
    bus.tlb_res       = '0;
    bus.tlb_done      = 1'b0;
    bus.tlb_probe_hit = 1'b0;
    bus.tlb_probe_idx = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    checkOutput("rstReady", 32'(bus.op_ready), 32'd1);
    checkOutput("rstDone", 32'(bus.op_done), 32'd0);
    checkOutput("rstReq", 32'(bus.tlb_req), 32'(REQ_NONE));
    pushRead("rstIndex", CP0_INDEX, 32'h0);
    pushRead("rstRandom", CP0_RANDOM, 32'd31);
    pushRead("rstLo0", CP0_ENTRYLO0, 32'h0);
    pushRead("rstLo1", CP0_ENTRYLO1, 32'h0);
    pushRead("rstWired", CP0_WIRED, 32'h0);
    pushRead("rstHi", CP0_ENTRYHI, 32'h0);
    drainReads();

    // Register masks and read-only behaviour.
    for (int i = 0; i < 10; i++) applyStimulus(regVecs[i]);

    // MFC0 must not see a write made in the same cycle.
    step();
    bus.cp0_we    = 1'b1;
    bus.cp0_waddr = CP0_ENTRYLO0;
    bus.cp0_wdata = 32'h0000_1234;
    bus.cp0_raddr = CP0_ENTRYLO0;
    @(negedge clk);
    checkOutput("noBypassOld", bus.cp0_rdata, 32'h03FF_FFFF);
    step();
    bus.cp0_we = 1'b0;
    @(negedge clk);
    checkOutput("noBypassNew", bus.cp0_rdata, 32'h0000_1234);

    // TLBWI with Index=5, three stalled WAIT cycles, MTC0 EntryLo0 during WB.
    mtc0(CP0_INDEX, 32'd5);
    runOp(OP_TLBWI, REQ_TLBWI, 5'd5, 32'h1234_4078, 3, 1'b0, 5'd0, '0,
          1'b1, CP0_ENTRYLO0, 32'h0000_0055);
    pushRead("wiIndexKept", CP0_INDEX, 32'h0000_0005);
    pushRead("wiHiKept", CP0_ENTRYHI, 32'h1234_4078);
    pushRead("wiMtc0InWb", CP0_ENTRYLO0, 32'h0000_0055);
    drainReads();

    // TLBP hit, miss, miss racing an MTC0 Index, then hit clearing P.
    runOp(OP_TLBP, REQ_TLBP, 5'd5, 32'h1234_4078, 0, 1'b1, 5'd17, '0, 1'b0, 5'd0, 32'h0);
    pushRead("probeHit", CP0_INDEX, 32'h0000_0011);
    drainReads();
    runOp(OP_TLBP, REQ_TLBP, 5'd17, 32'h1234_4078, 0, 1'b0, 5'd3, '0, 1'b0, 5'd0, 32'h0);
    pushRead("probeMiss", CP0_INDEX, 32'h8000_0011);
    drainReads();
    runOp(OP_TLBP, REQ_TLBP, 5'd17, 32'h1234_4078, 1, 1'b0, 5'd3, '0,
          1'b1, CP0_INDEX, 32'h0000_0009);
    pushRead("probeBeatsMtc0", CP0_INDEX, 32'h8000_0011);
    drainReads();
    mtc0(CP0_INDEX, 32'h0000_0002);
    @(negedge clk);
    pushRead("mtc0KeepsP", CP0_INDEX, 32'h8000_0002);
    drainReads();
    runOp(OP_TLBP, REQ_TLBP, 5'd2, 32'h1234_4078, 0, 1'b1, 5'd9, '0, 1'b0, 5'd0, 32'h0);
    pushRead("probeHitClearsP", CP0_INDEX, 32'h0000_0009);
    drainReads();

    // TLBR with all-ones EntryHi; MTC0 EntryLo1 in WB loses to the writeback.
    res.index    = 5'd0;
    res.entryhi  = 32'hFFFF_FFFF;
    res.entrylo0 = 32'hFFFF_FFFF;
    res.entrylo1 = 32'h1234_5678;
    res.pagemask = 32'hFFFF_FFFF;
    runOp(OP_TLBR, REQ_TLBR, 5'd9, 32'h1234_4078, 1, 1'b0, 5'd0, res,
          1'b1, CP0_ENTRYLO1, 32'h0000_0000);
    pushRead("tlbrHi", CP0_ENTRYHI, 32'hFFFF_E0FF);
    pushRead("tlbrLo0", CP0_ENTRYLO0, 32'h03FF_FFFF);
    pushRead("tlbrLo1", CP0_ENTRYLO1, 32'h0234_5678);
    drainReads();

    // TLBWR: Wired=4 sets Random to 31; one more edge before accept gives 30.
    mtc0(CP0_WIRED, 32'd4);
    runOp(OP_TLBWR, REQ_TLBWR, 5'd30, 32'hFFFF_E0FF, 0, 1'b0, 5'd0, '0, 1'b0, 5'd0, 32'h0);

    // Random countdown with Wired=4 over 40 cycles.
    mtc0(CP0_WIRED, 32'd4);
    bus.cp0_raddr = CP0_RANDOM;
    expRandom = 32'd31;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput("randomSeq", bus.cp0_rdata, expRandom);
      expRandom = (expRandom == 32'd4) ? 32'd31 : expRandom - 32'd1;
      step();
    end

    // Exception while a TLBWI waits: abort, VPN2 loaded, ASID kept.
    mtc0(CP0_ENTRYHI, 32'h0000_00AB);
    step();
    bus.op_valid = 1'b1;
    bus.op_code  = OP_TLBWI;
    step();
    bus.op_valid = 1'b0;
    step();
    bus.exc_valid = 1'b1;
    bus.exc_vaddr = 32'h0040_3ABC;
    @(negedge clk);
    checkOutput("excWaitReq", 32'(bus.tlb_req), 32'(REQ_TLBWI));
    checkOutput("excNoDone", 32'(bus.op_done), 32'd0);
    step();
    bus.exc_valid = 1'b0;
    @(negedge clk);
    checkOutput("excToIdleReq", 32'(bus.tlb_req), 32'(REQ_NONE));
    checkOutput("excToIdleReady", 32'(bus.op_ready), 32'd1);
    pushRead("excEntryHi", CP0_ENTRYHI, 32'h0040_20AB);
    drainReads();
    step();
    bus.tlb_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("excNoLateDone", 32'(bus.op_done), 32'd0);
      step();
      bus.tlb_done = 1'b0;
    end

    // Exception in IDLE blocks acceptance of a presented op.
    bus.op_valid  = 1'b1;
    bus.op_code   = OP_TLBR;
    bus.exc_valid = 1'b1;
    bus.exc_vaddr = 32'hFFFF_E000;
    @(negedge clk);
    checkOutput("excBlocksReady", 32'(bus.op_ready), 32'd0);
    step();
    bus.op_valid  = 1'b0;
    bus.exc_valid = 1'b0;
    @(negedge clk);
    checkOutput("excNotAccepted", 32'(bus.tlb_req), 32'(REQ_NONE));
    pushRead("excIdleHi", CP0_ENTRYHI, 32'hFFFF_E0AB);
    drainReads();

    // Reset asserted mid-cycle during WAIT of a TLBR.
    step();
    bus.op_valid = 1'b1;
    bus.op_code  = OP_TLBR;
    step();
    bus.op_valid = 1'b0;
    step();
    #2 resetn = 1'b0;
    #1;
    checkOutput("rstMidReq", 32'(bus.tlb_req), 32'(REQ_NONE));
    checkOutput("rstMidDone", 32'(bus.op_done), 32'd0);
    pushRead("rstMidIndex", CP0_INDEX, 32'h0);
    pushRead("rstMidRandom", CP0_RANDOM, 32'd31);
    pushRead("rstMidLo0", CP0_ENTRYLO0, 32'h0);
    pushRead("rstMidLo1", CP0_ENTRYLO1, 32'h0);
    pushRead("rstMidWired", CP0_WIRED, 32'h0);
    pushRead("rstMidHi", CP0_ENTRYHI, 32'h0);
    drainReads();
    bus.tlb_done = 1'b1;
    bus.tlb_res  = res;
    step();
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rstRelReady", 32'(bus.op_ready), 32'd1);
    checkOutput("rstRelNoDone", 32'(bus.op_done), 32'd0);
    step();
    bus.tlb_done = 1'b0;
    @(negedge clk);
    checkOutput("rstNoWbDone", 32'(bus.op_done), 32'd0);
    pushRead("rstNoWbHi", CP0_ENTRYHI, 32'h0);
    drainReads();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
